// File: rtl/ntt_bf_sched_if.sv
// Handshake and memory-control bundle between the NTT stage scheduler and its neighbours.
// master: the requester / address-generator side; slave: the scheduler itself.
interface ntt_bf_sched_if #(
    parameter int unsigned CNT_W = 7,
    parameter int unsigned TW_W  = 8
);
    logic             start;
    logic             ntt_mode;
    logic             busy;
    logic             done;
    logic             sel;
    logic             sel_ntt;
    logic             rd_en;
    logic [CNT_W-1:0] rd_cnt;
    logic [2:0]       rd_stage;
    logic [TW_W-1:0]  tw_addr;
    logic             wr_en;
    logic [CNT_W-1:0] wr_cnt;
    logic [2:0]       wr_stage;

    modport master (
        output start, ntt_mode,
        input  busy, done, sel, sel_ntt, rd_en, rd_cnt, rd_stage, tw_addr,
        input  wr_en, wr_cnt, wr_stage
    );

    modport slave (
        input  start, ntt_mode,
        output busy, done, sel, sel_ntt, rd_en, rd_cnt, rd_stage, tw_addr,
        output wr_en, wr_cnt, wr_stage
    );
endinterface

// File: rtl/ntt_bf_sched.sv
// Stage scheduler for the 512-point mixed-radix NTT/INTT: four radix-4 stages and one radix-2
// stage, each 128 butterfly reads followed by a PIPE_LAT-cycle drain so writes land before the
// next stage reads. All outputs decode straight from flops.
module ntt_bf_sched #(
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned CNT_W    = 7,
    parameter int unsigned TW_W     = 8
) (
    input logic          clk,
    input logic          rst,
    ntt_bf_sched_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [3:0]       DrainMax = 4'(PIPE_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [2:0]       stage_q, stage_d;
    logic             mode_q, mode_d;
    logic             sel_q, sel_d;
    logic [TW_W-1:0]  tw_q, tw_d;
    logic [1:0]       r4_idx;

    logic             rd_en;
    logic [CNT_W-1:0] rd_cnt;
    logic [2:0]       rd_stage;

    logic             dl_en_q    [PIPE_LAT];
    logic [CNT_W-1:0] dl_cnt_q   [PIPE_LAT];
    logic [2:0]       dl_stage_q [PIPE_LAT];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            stage_q <= '0;
            mode_q  <= 1'b0;
            sel_q   <= 1'b0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            stage_q <= stage_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            tw_q    <= tw_d;
        end
    end

    // Next-state: stage sequencing, counters, radix select and twiddle address
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        stage_d = stage_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        tw_d    = '0;
        r4_idx  = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    mode_d  = bus.ntt_mode;
                    stage_d = '0;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    sel_d   = !bus.ntt_mode;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntMax) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                    dcnt_d  = '0;
                end
            end
            StDrain: begin
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DrainMax) begin
                    dcnt_d = '0;
                    if (stage_q < 3'd4) begin
                        state_d = StRun;
                        stage_d = stage_q + 1'b1;
                        // Forward: radix-2 last; inverse: radix-2 first
                        sel_d   = mode_q ? (stage_d != 3'd0) : (stage_d != 3'd4);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Address for the read issued next cycle; zero whenever no read is issued
        if (state_d == StRun) begin
            if (sel_d) begin
                // INTT radix-4 stages start at stage 1, so shift the index down by one
                r4_idx = stage_d[1:0] - {1'b0, mode_d};
                unique case (r4_idx)
                    2'd0: tw_d = TW_W'(cnt_d >> 7);
                    2'd1: tw_d = TW_W'(1) + TW_W'(cnt_d >> 5);
                    2'd2: tw_d = TW_W'(5) + TW_W'(cnt_d >> 3);
                    2'd3: tw_d = TW_W'(21) + TW_W'(cnt_d >> 1);
                    default: tw_d = '0;
                endcase
            end else begin
                tw_d = TW_W'(85) + TW_W'(cnt_d);
            end
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        rd_en        = (state_q == StRun);
        rd_cnt       = rd_en ? cnt_q : '0;
        rd_stage     = rd_en ? stage_q : '0;
        bus.busy     = (state_q == StRun) || (state_q == StDrain);
        bus.done     = (state_q == StDone);
        bus.sel      = sel_q;
        bus.sel_ntt  = mode_q;
        bus.rd_en    = rd_en;
        bus.rd_cnt   = rd_cnt;
        bus.rd_stage = rd_stage;
        bus.tw_addr  = tw_q;
        bus.wr_en    = dl_en_q[PIPE_LAT-1];
        bus.wr_cnt   = dl_cnt_q[PIPE_LAT-1];
        bus.wr_stage = dl_stage_q[PIPE_LAT-1];
    end

    // Write-side delay line matching the butterfly pipeline latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                dl_en_q[i]    <= 1'b0;
                dl_cnt_q[i]   <= '0;
                dl_stage_q[i] <= '0;
            end
        end else begin
            dl_en_q[0]    <= rd_en;
            dl_cnt_q[0]   <= rd_cnt;
            dl_stage_q[0] <= rd_stage;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                dl_en_q[i]    <= dl_en_q[i-1];
                dl_cnt_q[i]   <= dl_cnt_q[i-1];
                dl_stage_q[i] <= dl_stage_q[i-1];
            end
        end
    end

endmodule
